// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and encodings for the multicycle CPU controller.
//   state_e          controller states (StIrq only exists when CTRL_IRQ_EN is defined)
//   MAJ_*            opcode[5:4] major field values
//   OP_*             I-type sub-opcodes (opcode[3:0])
//   ALU_ADD/ALU_SUB  ALU operation codes
//   MTR_*/PCS_*/SRCB_*  datapath mux encodings
// Configuration macro: CTRL_IRQ_EN adds the interrupt-entry state.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        StRst, StIf, StId, StExR, StExIs, StExIz, StR1Rd, StBrc, StJmp,
        StMemRd, StMemWr, StWbAlu, StWbMdr, StWbLi, StWbLui, StErr
`ifdef CTRL_IRQ_EN
        , StIrq
`endif
    } state_e;

    localparam logic [1:0] MAJ_J  = 2'b00;
    localparam logic [1:0] MAJ_R  = 2'b01;
    localparam logic [1:0] MAJ_BR = 2'b10;
    localparam logic [1:0] MAJ_I  = 2'b11;

    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ORI  = 4'h4;
    localparam logic [3:0] OP_ANDI = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_SLTI = 4'h7;
    localparam logic [3:0] OP_LI   = 4'h9;
    localparam logic [3:0] OP_LUI  = 4'hA;
    localparam logic [3:0] OP_LWI  = 4'hB;
    localparam logic [3:0] OP_SWI  = 4'hC;

    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MDR = 2'b01;
    localparam logic [1:0] MTR_LI  = 2'b10;
    localparam logic [1:0] MTR_LUI = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
    localparam logic [1:0] PCS_VEC = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_ZIMM = 2'b11;

    // States that wait on a memory ready and therefore own the wait counter.
    function automatic logic is_wait_state(state_e s);
        return (s == StIf) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts consecutive wait cycles in a memory state.
//   clk, reset_n  clock and asynchronous active-low reset
//   clear         zero the count (state entry)
//   enable        count this cycle (ready low)
//   limit_hit     count equals WAIT_MAX; never asserted when WAIT_MAX is 0
module ctrl_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);

    localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign limit_hit = (WAIT_MAX != 0) && (cnt_q == CntW'(WAIT_MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !limit_hit) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the 32-bit multicycle CPU.
//   clk, reset_n          clock, asynchronous active-low reset
//   opcode[5:0]           IR[31:26]
//   imem_ready/dmem_ready memory handshakes; irq level interrupt request
//   PCWrite..ALUSrcA      datapath strobes/selects; MemtoReg, PCSource, ALUSrcB mux selects
//   ALUSel                ALU operation (opcode[3:0] zero-extended in execute states)
//   EPCWrite, irq_ack     interrupt entry strobes (tied low without CTRL_IRQ_EN)
//   illegal_op            one-cycle pulse after decoding an unknown I-type opcode
//   bus_err               sticky wait-state timeout flag
// Configuration macro: CTRL_IRQ_EN enables interrupt entry at instruction boundaries.
module multicycle_ctrl #(
    parameter int unsigned ALUSEL_W = 4,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                irq,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IRWrite,
    output logic                DMEMWrite,
    output logic                DMEMRead,
    output logic                RegWrite,
    output logic                RegReadSel,
    output logic                ALUSrcA,
    output logic [1:0]          MemtoReg,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUSrcB,
    output logic [ALUSEL_W-1:0] ALUSel,
    output logic                EPCWrite,
    output logic                irq_ack,
    output logic                illegal_op,
    output logic                bus_err
);
    import cpu_ctrl_pkg::*;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [1:0] major;
    logic [3:0] sub;
    logic       timer_clear, timer_en, limit_hit;

    assign major = opcode[5:4];
    assign sub   = opcode[3:0];

`ifndef CTRL_IRQ_EN
    logic unused_irq;
    assign unused_irq = irq;
`endif

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        unique case (state_q)
            StRst: state_d = StIf;
            StIf: begin
                if (imem_ready)     state_d = StId;
                else if (limit_hit) state_d = StErr;
            end
            StId: begin
                unique case (major)
                    MAJ_J:  state_d = (sub == 4'h0) ? StIf : StJmp;
                    MAJ_R:  state_d = StExR;
                    MAJ_BR: state_d = StR1Rd;
                    MAJ_I: begin
                        case (sub)
                            OP_ADDI, OP_SUBI, OP_SLTI: state_d = StExIs;
                            OP_ORI, OP_ANDI, OP_XORI:  state_d = StExIz;
                            OP_LWI:                    state_d = StMemRd;
                            OP_LI, OP_LUI, OP_SWI:     state_d = StR1Rd;
                            default: begin
                                state_d   = StIf;
                                illegal_d = 1'b1;
                            end
                        endcase
                    end
                endcase
            end
            StExR, StExIs, StExIz: state_d = StWbAlu;
            StR1Rd: begin
                if (major == MAJ_BR) begin
                    state_d = StBrc;
                end else begin
                    case (sub)
                        OP_LI:   state_d = StWbLi;
                        OP_LUI:  state_d = StWbLui;
                        OP_SWI:  state_d = StMemWr;
                        default: state_d = StIf;
                    endcase
                end
            end
            StMemRd: begin
                if (dmem_ready)     state_d = StWbMdr;
                else if (limit_hit) state_d = StErr;
            end
            StMemWr: begin
                if (dmem_ready)     state_d = StIf;
                else if (limit_hit) state_d = StErr;
            end
            StWbAlu, StWbMdr, StWbLi, StWbLui, StBrc, StJmp: state_d = StIf;
            StErr: state_d = StErr;
`ifdef CTRL_IRQ_EN
            StIrq: state_d = StIf;
`endif
            default: state_d = StRst;
        endcase
`ifdef CTRL_IRQ_EN
        // Divert only instruction-boundary entries into IF; fetch stalls, reset
        // exit and the IRQ state itself are not boundaries.
        if (irq && (state_d == StIf) && (state_q != StIf) && (state_q != StRst) &&
            (state_q != StIrq)) begin
            state_d = StIrq;
        end
`endif
    end

    assign timer_clear = (state_d != state_q) && is_wait_state(state_d);
    assign timer_en    = ((state_q == StIf) && !imem_ready) ||
                         (((state_q == StMemRd) || (state_q == StMemWr)) && !dmem_ready);

    ctrl_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (timer_clear),
        .enable    (timer_en),
        .limit_hit (limit_hit)
    );

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        DMEMWrite   = 1'b0;
        DMEMRead    = 1'b0;
        RegWrite    = 1'b0;
        RegReadSel  = 1'b0;
        ALUSrcA     = 1'b0;
        MemtoReg    = MTR_ALU;
        PCSource    = PCS_ALU;
        ALUSrcB     = SRCB_REG;
        ALUSel      = '0;
        EPCWrite    = 1'b0;
        irq_ack     = 1'b0;
        bus_err     = 1'b0;
        unique case (state_q)
            StRst: begin
                PCWrite  = 1'b1;
                PCSource = PCS_VEC;
            end
            StIf: begin
                PCWrite = imem_ready;
                IRWrite = imem_ready;
                ALUSrcB = SRCB_FOUR;
                ALUSel  = ALUSEL_W'(ALU_ADD);
            end
            StId: begin
                ALUSrcB = SRCB_IMM;
                ALUSel  = ALUSEL_W'(ALU_ADD);
            end
            StExR, StExIs, StExIz: begin
                ALUSrcA = 1'b1;
                ALUSel  = ALUSEL_W'(sub);
                if (state_q == StExIs)      ALUSrcB = SRCB_IMM;
                else if (state_q == StExIz) ALUSrcB = SRCB_ZIMM;
            end
            StR1Rd: begin
                RegReadSel = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUSel     = ALUSEL_W'(ALU_ADD);
            end
            StBrc: begin
                PCWriteCond = 1'b1;
                PCSource    = PCS_BR;
                ALUSrcA     = 1'b1;
                ALUSel      = ALUSEL_W'(ALU_SUB);
                RegReadSel  = 1'b1;
            end
            StJmp: begin
                PCWrite  = 1'b1;
                PCSource = PCS_JMP;
            end
            StMemRd: DMEMRead  = 1'b1;
            StMemWr: DMEMWrite = 1'b1;
            StWbAlu: RegWrite  = 1'b1;
            StWbMdr: begin
                RegWrite = 1'b1;
                MemtoReg = MTR_MDR;
            end
            StWbLi: begin
                RegWrite = 1'b1;
                MemtoReg = MTR_LI;
            end
            StWbLui: begin
                RegWrite = 1'b1;
                MemtoReg = MTR_LUI;
            end
            StErr: bus_err = 1'b1;
`ifdef CTRL_IRQ_EN
            StIrq: begin
                PCWrite  = 1'b1;
                PCSource = PCS_VEC;
                EPCWrite = 1'b1;
                irq_ack  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign illegal_op = illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRst;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: builds per-cycle expected output vectors from the
// instruction-level behaviour (phase sequence, wait counts, irq entry) and
// compares them against the DUT at each negative clock edge.
module tb_multicycle_ctrl;

    localparam int WMAX = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       irq = 1'b0;
    logic       PCWrite, PCWriteCond, IRWrite, DMEMWrite, DMEMRead, RegWrite, RegReadSel;
    logic       ALUSrcA, EPCWrite, irq_ack, illegal_op, bus_err;
    logic [1:0] MemtoReg, PCSource, ALUSrcB;
    logic [3:0] ALUSel;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .ALUSEL_W (4),
        .WAIT_MAX (WMAX)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .opcode      (opcode),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .irq         (irq),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IRWrite     (IRWrite),
        .DMEMWrite   (DMEMWrite),
        .DMEMRead    (DMEMRead),
        .RegWrite    (RegWrite),
        .RegReadSel  (RegReadSel),
        .ALUSrcA     (ALUSrcA),
        .MemtoReg    (MemtoReg),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUSel      (ALUSel),
        .EPCWrite    (EPCWrite),
        .irq_ack     (irq_ack),
        .illegal_op  (illegal_op),
        .bus_err     (bus_err)
    );

    // [21]PCWrite [20]PCWriteCond [19]IRWrite [18]DMEMWrite [17]DMEMRead [16]RegWrite
    // [15]RegReadSel [14]ALUSrcA [13:12]MemtoReg [11:10]PCSource [9:8]ALUSrcB [7:4]ALUSel
    // [3]EPCWrite [2]irq_ack [1]illegal_op [0]bus_err
    typedef logic [21:0] ovec_t;
    typedef struct packed {
        logic [5:0] op;
        logic       ir;
        logic       dr;
        logic       iq;
        ovec_t      want;
    } cyc_t;

    localparam ovec_t EPC  = 22'h8;
    localparam ovec_t ACK  = 22'h4;
    localparam ovec_t ILL  = 22'h2;
    localparam ovec_t BERR = 22'h1;
    localparam logic [3:0] ADD = 4'd2;
    localparam logic [3:0] SUB = 4'd3;

    ovec_t obs;
    assign obs = {PCWrite, PCWriteCond, IRWrite, DMEMWrite, DMEMRead, RegWrite, RegReadSel,
                  ALUSrcA, MemtoReg, PCSource, ALUSrcB, ALUSel, EPCWrite, irq_ack,
                  illegal_op, bus_err};

    int    total = 0;
    int    bad = 0;
    bit    pend_ill = 1'b0;
    cyc_t  q[$];
    ovec_t obsq[$];

    function automatic ovec_t v(logic pcw, logic pcwc, logic irw, logic dw, logic dr,
                                logic rw, logic rrs, logic asa, logic [1:0] mtr,
                                logic [1:0] pcs, logic [1:0] asb, logic [3:0] alu);
        return {pcw, pcwc, irw, dw, dr, rw, rrs, asa, mtr, pcs, asb, alu, 4'b0000};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // A pending illegal_op pulse lands on whichever cycle follows the decode.
    task automatic push(input logic [5:0] op, input logic ir, input logic dr,
                        input logic iq, input ovec_t w);
        cyc_t c;
        c.op   = op;
        c.ir   = ir;
        c.dr   = dr;
        c.iq   = iq;
        c.want = w | (pend_ill ? ILL : 22'h0);
        pend_ill = 1'b0;
        q.push_back(c);
    endtask

    // Instruction-level reference: iw fetch stalls, dw data-memory stalls, irq held
    // for the whole instruction. err reports a wait-state timeout (ends in ERR).
    task automatic model_instr(input logic [5:0] op, input int iw, input int dw,
                               input logic iq, output bit err);
        logic [1:0] maj;
        logic [3:0] sub;
        bit         mrd, mwr, ill;
        ovec_t      mv;
        maj = op[5:4];
        sub = op[3:0];
        mrd = 0; mwr = 0; ill = 0; err = 0;
        for (int k = 0; k < iw; k++)
            push(op, 1'b0, rb(), iq, v(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd1, ADD));
        push(op, 1'b1, rb(), iq, v(1,0,1,0,0,0,0,0, 2'd0, 2'd0, 2'd1, ADD));
        push(op, rb(), rb(), iq, v(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd2, ADD));
        case (maj)
            2'b00: if (sub != 4'd0) push(op, rb(), rb(), iq, v(1,0,0,0,0,0,0,0, 2'd0, 2'd2, 2'd0, 4'd0));
            2'b01: begin
                push(op, rb(), rb(), iq, v(0,0,0,0,0,0,0,1, 2'd0, 2'd0, 2'd0, sub));
                push(op, rb(), rb(), iq, v(0,0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd0, 4'd0));
            end
            2'b10: begin
                push(op, rb(), rb(), iq, v(0,0,0,0,0,0,1,0, 2'd0, 2'd0, 2'd2, ADD));
                push(op, rb(), rb(), iq, v(0,1,0,0,0,0,1,1, 2'd0, 2'd1, 2'd0, SUB));
            end
            default: begin
                if (sub == 4'd2 || sub == 4'd3 || sub == 4'd7 ||
                    sub == 4'd4 || sub == 4'd5 || sub == 4'd6) begin
                    push(op, rb(), rb(), iq, v(0,0,0,0,0,0,0,1, 2'd0, 2'd0,
                         (sub >= 4'd4 && sub <= 4'd6) ? 2'd3 : 2'd2, sub));
                    push(op, rb(), rb(), iq, v(0,0,0,0,0,1,0,0, 2'd0, 2'd0, 2'd0, 4'd0));
                end else if (sub == 4'hB) begin
                    mrd = 1;
                end else if (sub == 4'h9 || sub == 4'hA || sub == 4'hC) begin
                    push(op, rb(), rb(), iq, v(0,0,0,0,0,0,1,0, 2'd0, 2'd0, 2'd2, ADD));
                    if (sub == 4'h9)
                        push(op, rb(), rb(), iq, v(0,0,0,0,0,1,0,0, 2'd2, 2'd0, 2'd0, 4'd0));
                    else if (sub == 4'hA)
                        push(op, rb(), rb(), iq, v(0,0,0,0,0,1,0,0, 2'd3, 2'd0, 2'd0, 4'd0));
                    else
                        mwr = 1;
                end else begin
                    ill = 1;
                end
            end
        endcase
        if (mrd || mwr) begin
            mv = mrd ? v(0,0,0,0,1,0,0,0, 2'd0, 2'd0, 2'd0, 4'd0)
                     : v(0,0,0,1,0,0,0,0, 2'd0, 2'd0, 2'd0, 4'd0);
            if (WMAX != 0 && dw > WMAX) begin
                for (int k = 0; k <= WMAX; k++) push(op, rb(), 1'b0, iq, mv);
                err = 1;
            end else begin
                for (int k = 0; k < dw; k++) push(op, rb(), 1'b0, iq, mv);
                push(op, rb(), 1'b1, iq, mv);
                if (mrd) push(op, rb(), rb(), iq, v(0,0,0,0,0,1,0,0, 2'd1, 2'd0, 2'd0, 4'd0));
            end
        end
        if (ill) pend_ill = 1'b1;
`ifdef CTRL_IRQ_EN
        if (iq && !err)
            push(op, rb(), rb(), 1'b0, v(1,0,0,0,0,0,0,0, 2'd0, 2'd3, 2'd0, 4'd0) | EPC | ACK);
`endif
    endtask

    // Applies q cycle by cycle (entered just after a rising edge) and records outputs.
    task automatic play();
        obsq.delete();
        foreach (q[i]) begin
            opcode     = q[i].op;
            imem_ready = q[i].ir;
            dmem_ready = q[i].dr;
            irq        = q[i].iq;
            @(negedge clk);
            obsq.push_back(obs);
            @(posedge clk);
            #1;
        end
    endtask

    localparam ovec_t RSTV = 22'h200C00;  // PCWrite=1, PCSource=11

    task automatic test_reset();
        reset_n = 1'b0;
        irq = 1'b1;
        repeat (3) begin
            opcode = 6'($urandom); imem_ready = rb(); dmem_ready = rb();
            @(negedge clk);
            total++;
            if (obs !== RSTV) begin
                bad++;
                $display("FAIL reset_hold: got %b want %b", obs, RSTV);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== RSTV) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", obs, RSTV);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch_nop();
        bit e;
        q.delete();
        repeat (3) model_instr(6'b000000, 0, 0, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL fetch_nop cyc %0d: got %b want %b", i, obsq[i], q[i].want);
            end
        end
    endtask

    task automatic test_rtype();
        bit e;
        q.delete();
        model_instr(6'b010010, 0, 0, 1'b0, e);
        model_instr(6'b000101, 1, 0, 1'b0, e);
        model_instr(6'b100001, 0, 0, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL rtype_j_br cyc %0d: got %b want %b", i, obsq[i], q[i].want);
            end
        end
    endtask

    task automatic test_lwi_waits();
        bit e;
        q.delete();
        model_instr(6'b111011, 0, 3, 1'b0, e);
        model_instr(6'b111011, 0, WMAX, 1'b0, e);   // ready arrives on the limit cycle
        model_instr(6'b111100, 2, WMAX, 1'b0, e);
        model_instr(6'b000000, WMAX, 0, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL lwi_waits cyc %0d: got %b want %b", i, obsq[i], q[i].want);
            end
        end
    endtask

    task automatic test_illegal();
        bit e;
        q.delete();
        model_instr(6'b111111, 0, 0, 1'b0, e);
        model_instr(6'b000000, 1, 0, 1'b0, e);
        model_instr(6'b110000, 0, 0, 1'b1, e);
        model_instr(6'b000000, 0, 0, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL illegal cyc %0d: got %b want %b", i, obsq[i], q[i].want);
            end
        end
    endtask

    task automatic test_irq();
        bit e;
        q.delete();
        model_instr(6'b010010, 0, 0, 1'b1, e);
        model_instr(6'b000000, 0, 0, 1'b1, e);
        model_instr(6'b111100, 1, 2, 1'b1, e);
        model_instr(6'b000000, 0, 0, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL irq cyc %0d: got %b want %b", i, obsq[i], q[i].want);
            end
        end
    endtask

    task automatic test_random();
        bit e;
        q.delete();
        for (int n = 0; n < 80; n++)
            model_instr(6'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, WMAX)),
                        1'($urandom_range(0, 3) == 0), e);
        model_instr(6'b000000, 0, 0, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL random cyc %0d op %b: got %b want %b", i, q[i].op, obsq[i],
                         q[i].want);
            end
        end
    endtask

    task automatic test_timeout();
        bit e;
        q.delete();
        model_instr(6'b111100, 0, WMAX + 1, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL timeout cyc %0d: got %b want %b", i, obsq[i], q[i].want);
            end
        end
        // ERR is terminal regardless of inputs.
        for (int k = 0; k < 6; k++) begin
            opcode = 6'($urandom); imem_ready = rb(); dmem_ready = rb(); irq = 1'b1;
            @(negedge clk);
            total++;
            if (obs !== BERR) begin
                bad++;
                $display("FAIL err_sticky cyc %0d: got %b want %b", k, obs, BERR);
            end
            @(posedge clk);
            #1;
        end
        // Asynchronous reset takes effect before the next clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (obs !== RSTV) begin
            bad++;
            $display("FAIL async_reset: got %b want %b", obs, RSTV);
        end
        pend_ill = 1'b0;
        @(posedge clk);
        #1;
        irq = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== RSTV) begin
            bad++;
            $display("FAIL reset_after_err: got %b want %b", obs, RSTV);
        end
        @(posedge clk);
        #1;
        q.delete();
        model_instr(6'b000000, 0, 0, 1'b0, e);
        model_instr(6'b010011, 0, 0, 1'b0, e);
        play();
        foreach (q[i]) begin
            total++;
            if (obsq[i] !== q[i].want) begin
                bad++;
                $display("FAIL recover cyc %0d: got %b want %b", i, obsq[i], q[i].want);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_nop();
        test_rtype();
        test_lwi_waits();
        test_illegal();
        test_irq();
        test_random();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
